// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, reads one 16-bit word per fetch from a
// synchronous-read RAM and holds it for the decoder. Optional macro: FETCH_LINK_EN (link_addr output).
module fetch_unit #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                RAM_LAT  = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [15:0]       mem_rdata,
    input  logic              en_pc,
    input  logic              pc_mux_en,
    input  logic              abs_sel,
    input  logic [7:0]        disp,
    input  logic [ADDR_W-1:0] jmp_addr,
    output logic [15:0]       instr,
    output logic              instr_valid,
`ifdef FETCH_LINK_EN
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] link_addr
`else
    output logic [ADDR_W-1:0] pc
`endif
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [1:0] LAT_INIT = 2'(RAM_LAT - 1);

    state_t            state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc_d;
    logic [ADDR_W-1:0] addr_q;
    logic              rd_en_q;
    logic [15:0]       instr_q;
    logic              valid_q;
    logic [1:0]        lat_q;
`ifdef FETCH_LINK_EN
    logic [ADDR_W-1:0] link_q;
`endif

    // Branch target arithmetic wraps naturally at ADDR_W bits.
    always_comb begin
        pc_d = pc_q + ADDR_W'(1);
        if (pc_mux_en) begin
            if (abs_sel) begin
                pc_d = jmp_addr;
            end else begin
                pc_d = pc_q + {{(ADDR_W-8){disp[7]}}, disp};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            rd_en_q <= 1'b0;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
            lat_q   <= 2'd0;
`ifdef FETCH_LINK_EN
            link_q  <= RESET_PC;
`endif
        end else begin
            case (state_q)
                // Strobe is raised on entry from HOLD; after reset it is
                // raised on the first edge so reset itself keeps it low.
                S_REQ: begin
                    if (!rd_en_q) begin
                        rd_en_q <= 1'b1;
                    end else begin
                        rd_en_q <= 1'b0;
                        lat_q   <= LAT_INIT;
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (lat_q == 2'd0) begin
                        instr_q <= mem_rdata;
                        valid_q <= 1'b1;
                        state_q <= S_HOLD;
                    end else begin
                        lat_q <= lat_q - 2'd1;
                    end
                end
                S_HOLD: begin
                    if (en_pc) begin
                        valid_q <= 1'b0;
                        pc_q    <= pc_d;
                        addr_q  <= pc_d;
                        rd_en_q <= 1'b1;
                        state_q <= S_REQ;
`ifdef FETCH_LINK_EN
                        if (pc_mux_en) begin
                            link_q <= pc_q + ADDR_W'(1);
                        end
`endif
                    end
                end
                default: begin
                    state_q <= S_REQ;
                    rd_en_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_addr    = addr_q;
    assign mem_rd_en   = rd_en_q;
    assign instr       = instr_q;
    assign instr_valid = valid_q;
    assign pc          = pc_q;
`ifdef FETCH_LINK_EN
    assign link_addr   = link_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: one instance at RAM_LAT=1, one at RAM_LAT=3,
// each fed by a behavioural RAM that drives junk outside its valid window.
module tb_fetch_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [15:0] ram_f(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input logic [31:0] act);
        n_tests++;
        n_fail++;
        $display("[TB] FAIL %s: got %h", nm, act);
    endtask

    // ---------------- instance A: RAM_LAT = 1 ----------------
    logic        reset_a = 1'b1, en_pc_a = 1'b0, mux_a = 1'b0, abs_a = 1'b0;
    logic [7:0]  disp_a = 8'h00;
    logic [15:0] jmp_a = 16'h0000;
    logic [15:0] mem_addr_a, instr_a, pc_a;
    logic [15:0] rdata_a = 16'hBAD1;
    logic        rd_en_a, valid_a;
`ifdef FETCH_LINK_EN
    logic [15:0] link_a;
`endif

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .RAM_LAT(1)) u_dut_a (
        .clk(clk), .reset(reset_a), .mem_addr(mem_addr_a), .mem_rd_en(rd_en_a),
        .mem_rdata(rdata_a), .en_pc(en_pc_a), .pc_mux_en(mux_a), .abs_sel(abs_a),
        .disp(disp_a), .jmp_addr(jmp_a), .instr(instr_a), .instr_valid(valid_a),
`ifdef FETCH_LINK_EN
        .pc(pc_a), .link_addr(link_a)
`else
        .pc(pc_a)
`endif
    );

    always @(posedge clk) rdata_a <= rd_en_a ? ram_f(mem_addr_a) : 16'hBAD1;

    // ---------------- instance B: RAM_LAT = 3 ----------------
    logic        reset_b = 1'b1, en_pc_b = 1'b0, mux_b = 1'b0, abs_b = 1'b0;
    logic [7:0]  disp_b = 8'h00;
    logic [15:0] jmp_b = 16'h0000;
    logic [15:0] mem_addr_b, instr_b, pc_b, rdata_b;
    logic        rd_en_b, valid_b;
    logic        v1 = 1'b0, v2 = 1'b0, v3 = 1'b0;
    logic [15:0] a1 = '0, a2 = '0, a3 = '0;
`ifdef FETCH_LINK_EN
    logic [15:0] link_b;
`endif

    fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000), .RAM_LAT(3)) u_dut_b (
        .clk(clk), .reset(reset_b), .mem_addr(mem_addr_b), .mem_rd_en(rd_en_b),
        .mem_rdata(rdata_b), .en_pc(en_pc_b), .pc_mux_en(mux_b), .abs_sel(abs_b),
        .disp(disp_b), .jmp_addr(jmp_b), .instr(instr_b), .instr_valid(valid_b),
`ifdef FETCH_LINK_EN
        .pc(pc_b), .link_addr(link_b)
`else
        .pc(pc_b)
`endif
    );

    always @(posedge clk) begin
        v1 <= rd_en_b; a1 <= mem_addr_b;
        v2 <= v1;      a2 <= a1;
        v3 <= v2;      a3 <= a2;
    end
    assign rdata_b = v3 ? ram_f(a3) : 16'hBAD3;

    // ---------------- scoreboards and monitors ----------------
    logic [15:0] exp_addr_a[$], exp_addr_b[$];
    logic [31:0] exp_out_a[$], exp_out_b[$];
    logic [31:0] cur_a = '0, cur_b = '0;
    logic        prev_valid_a = 1'b0, prev_valid_b = 1'b0;

    always @(negedge clk) begin
        if (rd_en_a) begin
            if (exp_addr_a.size() == 0) fail_now("a_unexpected_fetch", {16'h0, mem_addr_a});
            else chk("a_fetch_addr", {16'h0, mem_addr_a}, {16'h0, exp_addr_a.pop_front()});
        end
        if (valid_a && !prev_valid_a) begin
            if (exp_out_a.size() == 0) begin
                fail_now("a_unexpected_instr", {pc_a, instr_a});
            end else begin
                cur_a = exp_out_a.pop_front();
                chk("a_pc_instr", {pc_a, instr_a}, cur_a);
            end
        end else if (valid_a) begin
            chk("a_hold_stable", {pc_a, instr_a}, cur_a);
        end
        prev_valid_a = valid_a;
    end

    always @(negedge clk) begin
        if (rd_en_b) begin
            if (exp_addr_b.size() == 0) fail_now("b_unexpected_fetch", {16'h0, mem_addr_b});
            else chk("b_fetch_addr", {16'h0, mem_addr_b}, {16'h0, exp_addr_b.pop_front()});
        end
        if (valid_b && !prev_valid_b) begin
            if (exp_out_b.size() == 0) begin
                fail_now("b_unexpected_instr", {pc_b, instr_b});
            end else begin
                cur_b = exp_out_b.pop_front();
                chk("b_pc_instr", {pc_b, instr_b}, cur_b);
            end
        end else if (valid_b) begin
            chk("b_hold_stable", {pc_b, instr_b}, cur_b);
        end
        prev_valid_b = valid_b;
    end

    // ---------------- stimulus ----------------
    task automatic wait_valid_a();
        int n;
        n = 0;
        while (!valid_a && n < 40) begin @(posedge clk); #1; n++; end
        if (!valid_a) fail_now("a_hold_timeout", {31'h0, valid_a});
    endtask

    task automatic step_a(input logic m, input logic ab, input logic [7:0] d,
                          input logic [15:0] j, input logic [15:0] nxt, input logic [15:0] lnk);
        int n;
        wait_valid_a();
        mux_a = m; abs_a = ab; disp_a = d; jmp_a = j; en_pc_a = 1'b1;
        exp_addr_a.push_back(nxt);
        exp_out_a.push_back({nxt, ram_f(nxt)});
        @(posedge clk); #1;
        en_pc_a = 1'b0; mux_a = 1'b1; abs_a = 1'b1; disp_a = 8'h7F; jmp_a = 16'hDEAD;
        chk("a_pc_update", {16'h0, pc_a}, {16'h0, nxt});
        chk("a_valid_drop", {31'h0, valid_a}, 32'h0);
`ifdef FETCH_LINK_EN
        if (m) chk("a_link_addr", {16'h0, link_a}, {16'h0, lnk});
`endif
        n = 0;
        while (!valid_a && n < 40) begin @(posedge clk); #1; n++; end
        chk("a_refetch_latency", n, 2);
        $display("[TB] A fetch pc=%h instr=%h cycles=%0d link_exp=%h", pc_a, instr_a, n, lnk);
    endtask

    initial begin
        int n;
        exp_addr_a.push_back(16'h0000);
        exp_out_a.push_back({16'h0000, ram_f(16'h0000)});
        repeat (2) @(posedge clk);
        #1;
        chk("a_reset_instr", {16'h0, instr_a}, 32'h0);
        chk("a_reset_valid", {31'h0, valid_a}, 32'h0);
        chk("a_reset_rd_en", {31'h0, rd_en_a}, 32'h0);
        chk("a_reset_addr", {16'h0, mem_addr_a}, 32'h0);
        chk("a_reset_pc", {16'h0, pc_a}, 32'h0);
        $display("[TB] reset state checked");
        reset_a = 1'b0;

        step_a(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0001, 16'h0000);
        step_a(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0002, 16'h0000);
        step_a(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0003, 16'h0000);
        step_a(1'b1, 1'b1, 8'h00, 16'h0010, 16'h0010, 16'h0004);
        step_a(1'b1, 1'b0, 8'hFC, 16'h0000, 16'h000C, 16'h0011);
        step_a(1'b1, 1'b1, 8'h00, 16'h0010, 16'h0010, 16'h000D);
        step_a(1'b1, 1'b0, 8'h05, 16'h0000, 16'h0015, 16'h0011);
        step_a(1'b1, 1'b1, 8'h00, 16'h0020, 16'h0020, 16'h0016);
        step_a(1'b1, 1'b1, 8'h00, 16'h0300, 16'h0300, 16'h0021);
        step_a(1'b1, 1'b1, 8'h00, 16'hFFFF, 16'hFFFF, 16'h0301);
        step_a(1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 16'h0000);
        step_a(1'b1, 1'b1, 8'h00, 16'h0002, 16'h0002, 16'h0001);
        step_a(1'b1, 1'b0, 8'h80, 16'h0000, 16'hFF82, 16'h0003);
        step_a(1'b1, 1'b0, 8'h00, 16'h0000, 16'hFF82, 16'hFF83);
        wait_valid_a();

        // B: en_pc held high through REQ/WAIT; one fetch per HOLD.
        exp_addr_b.push_back(16'h0000);
        exp_addr_b.push_back(16'h0001);
        exp_addr_b.push_back(16'h0002);
        exp_addr_b.push_back(16'h0040);
        for (int k = 0; k < 3; k++) exp_out_b.push_back({16'(k), ram_f(16'(k))});
        en_pc_b = 1'b1;
        @(posedge clk); #1;
        reset_b = 1'b0;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (!valid_b && n < 40) begin
                chk("b_pc_until_hold", {16'h0, pc_b}, k);
                @(posedge clk); #1;
                n++;
            end
            if (!valid_b) fail_now("b_hold_timeout", {31'h0, valid_b});
            if (k > 0) chk("b_refetch_latency", n, 4);
            if (k == 2) begin mux_b = 1'b1; abs_b = 1'b1; jmp_b = 16'h0040; end
            @(posedge clk); #1;
            chk("b_pc_accept", {16'h0, pc_b}, (k == 2) ? 32'h40 : k + 1);
            chk("b_valid_drop", {31'h0, valid_b}, 32'h0);
            $display("[TB] B accept k=%0d pc=%h cycles=%0d", k, pc_b, n);
        end
        en_pc_b = 1'b0; mux_b = 1'b0; abs_b = 1'b0;

        // Reset while the fetch of 0x0040 is waiting on the RAM.
        @(posedge clk); #1;
        chk("b_wait_pc", {16'h0, pc_b}, 32'h40);
        chk("b_wait_valid", {31'h0, valid_b}, 32'h0);
        reset_b = 1'b1;
        #1;
        chk("b_rst_valid", {31'h0, valid_b}, 32'h0);
        chk("b_rst_instr", {16'h0, instr_b}, 32'h0);
        chk("b_rst_pc", {16'h0, pc_b}, 32'h0);
        chk("b_rst_addr", {16'h0, mem_addr_b}, 32'h0);
        chk("b_rst_rd_en", {31'h0, rd_en_b}, 32'h0);
        exp_addr_b.push_back(16'h0000);
        exp_out_b.push_back({16'h0000, ram_f(16'h0000)});
        @(posedge clk); #1;
        reset_b = 1'b0;
        $display("[TB] B reset in WAIT released");
        n = 0;
        while (!valid_b && n < 40) begin @(posedge clk); #1; n++; end
        if (!valid_b) fail_now("b_restart_timeout", {31'h0, valid_b});
        $display("[TB] B restart pc=%h instr=%h", pc_b, instr_b);

        repeat (3) @(posedge clk);
        #1;
        chk("a_queues_drained", exp_addr_a.size() + exp_out_a.size(), 0);
        chk("b_queues_drained", exp_addr_b.size() + exp_out_b.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
